// File: rtl/lfsr_pkg.sv
// Shared definitions for the parity-tagged 7-bit LFSR burst sequencer.
// Holds widths, tap positions, command encodings, FSM states and LFSR helpers.
package lfsr_pkg;

   localparam int LFSR_W = 7;
   localparam int TAP_HI = 6;
   localparam int TAP_LO = 5;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 7'h01;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_RUN  = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Shift left, feeding the tap XOR into bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], v[TAP_HI] ^ v[TAP_LO]};
   endfunction

   function automatic logic [LFSR_W:0] tag_parity(input logic [LFSR_W-1:0] v);
      return {~^v, v};
   endfunction

endpackage

// File: rtl/lfsr7_core.sv
// 7-bit LFSR register with load and step enables and a parity-tagged output byte.
// Load wins over step; the controller never requests both in one cycle.
module lfsr7_core
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [LFSR_W-1:0] load_val_i,
   input  logic              step_i,
   output logic [LFSR_W-1:0] state_o,
   output logic [LFSR_W:0]   data_o
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   // Next-state selection for the shift register.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = load_val_i;
      end else if (step_i) begin
         lfsr_d = lfsr_next(lfsr_q);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;
   assign data_o  = tag_parity(lfsr_q);

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// Command-driven burst sequencer: accepts seed loads and run bursts, streams
// parity-tagged LFSR words over valid/ready and supports abort.
module lfsr_burst_ctrl
   import lfsr_pkg::*;
#(
   parameter int                LEN_W        = 8,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [LFSR_W-1:0] cmd_seed,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              abort,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err_zero_seed,
   output logic [LEN_W-1:0]  remaining
);

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               cmd_fire_s;
   logic               load_s;
   logic               hs_s;
   logic               seed_zero_s;
   logic [LFSR_W-1:0]  load_val_s;
   logic [LFSR_W-1:0]  lfsr_state_s;

   assign cmd_fire_s  = cmd_valid && (state_q == ST_IDLE);
   assign load_s      = cmd_fire_s && (cmd_op == OP_LOAD);
   assign hs_s        = (state_q == ST_RUN) && out_ready;
   assign seed_zero_s = (cmd_seed == {LFSR_W{1'b0}});
   // A zero seed would lock the LFSR, so it is replaced by the default seed.
   assign load_val_s  = seed_zero_s ? DEFAULT_SEED : cmd_seed;

   lfsr7_core #(
      .SEED (DEFAULT_SEED)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load_s),
      .load_val_i (load_val_s),
      .step_i     (hs_s),
      .state_o    (lfsr_state_s),
      .data_o     (out_data)
   );

   // Controller next-state, counter and pulse generation.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire_s) begin
               case (cmd_op)
                  OP_LOAD: err_d = seed_zero_s;
                  OP_RUN: begin
                     if (cmd_len == {LEN_W{1'b0}}) begin
                        done_d = 1'b1;
                     end else begin
                        state_d     = ST_RUN;
                        remaining_d = cmd_len;
                     end
                  end
                  default: state_d = ST_IDLE;
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Abort still honours a same-cycle handshake; the core steps on hs_s.
            if (abort) begin
               state_d     = ST_IDLE;
               remaining_d = {LEN_W{1'b0}};
               done_d      = 1'b1;
            end else if (hs_s) begin
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            remaining_d = {LEN_W{1'b0}};
         end
      endcase
   end

   // Controller registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= {LEN_W{1'b0}};
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign cmd_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q == ST_RUN);
   assign out_valid     = (state_q == ST_RUN);
   assign out_last      = out_valid && (remaining_q == LEN_W'(1));
   assign done          = done_q;
   assign err_zero_seed = err_q;
   assign remaining     = remaining_q;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Scoreboard bench for lfsr_burst_ctrl: expected words are queued when a RUN
// is issued and popped as each word is handed over.
module tb_lfsr_burst_ctrl;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [6:0] cmd_seed;
   logic [7:0] cmd_len;
   logic       abort;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic       done;
   logic       err_zero_seed;
   logic [7:0] remaining;

   exp_t       exp_q[$];
   logic [6:0] m_lfsr;
   int         n_checks = 0;
   int         n_fail   = 0;

   lfsr_burst_ctrl #(.LEN_W(8), .DEFAULT_SEED(7'h01)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_seed(cmd_seed), .cmd_len(cmd_len), .abort(abort),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done),
      .err_zero_seed(err_zero_seed), .remaining(remaining)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] model_step(input logic [6:0] v);
      logic fb;
      fb = v[6] ^ v[5];
      return (v << 1) | {6'd0, fb};
   endfunction

   function automatic logic [7:0] model_word(input logic [6:0] v);
      int ones;
      ones = 0;
      for (int i = 0; i < 7; i++) ones += int'(v[i]);
      return {((ones % 2) == 0) ? 1'b1 : 1'b0, v};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_burst(input int n);
      logic [6:0] v;
      v = m_lfsr;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{data: model_word(v), last: (i == n - 1)});
         v = model_step(v);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [6:0] seed, input logic [7:0] len);
      cmd_valid = 1'b1; cmd_op = op; cmd_seed = seed; cmd_len = len;
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL cmd_ready_at_issue: got %b want 1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0; cmd_op = 2'b00;
   endtask

   // Pops and compares n_words handed-over words within a cycle budget.
   task automatic drain(input int n_words, input int max_cyc, output int cyc);
      exp_t e;
      int   got;
      got = 0; cyc = 0;
      while (got < n_words && exp_q.size() > 0 && cyc < max_cyc) begin
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            got++;
            n_checks++;
            if (out_data !== e.data) begin
               n_fail++; $display("FAIL out_data: got %h want %h", out_data, e.data);
            end
            n_checks++;
            if (out_last !== e.last) begin
               n_fail++; $display("FAIL out_last: got %b want %b (data %h)", out_last, e.last, e.data);
            end
            n_checks++;
            if (remaining !== 8'(exp_q.size() + 1)) begin
               n_fail++; $display("FAIL remaining: got %0d want %0d", remaining, exp_q.size() + 1);
            end
            m_lfsr = model_step(m_lfsr);
         end
         tick();
         cyc++;
      end
      n_checks++;
      if (got != n_words) begin
         n_fail++; $display("FAIL drain_timeout: got %0d words want %0d", got, n_words);
      end
   endtask

   task automatic check_end();
      n_checks++;
      if (out_valid !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_end: valid=%b done=%b ready=%b busy=%b want 0 1 1 0",
                  out_valid, done, cmd_ready, busy);
      end
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL done_one_cycle: got %b want 0", done);
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (out_data !== 8'h01 || cmd_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
          out_last !== 1'b0 || done !== 1'b0 || err_zero_seed !== 1'b0 || remaining !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_state: data=%h ready=%b busy=%b valid=%b last=%b done=%b err=%b rem=%0d want 01 1 0 0 0 0 0 0",
                  out_data, cmd_ready, busy, out_valid, out_last, done, err_zero_seed, remaining);
      end
   endtask

   task automatic test_basic_run();
      int cyc;
      issue(2'b10, 7'h00, 8'd4);
      push_burst(4);
      drain(4, 20, cyc);
      n_checks++;
      if (cyc != 4) begin
         n_fail++; $display("FAIL burst_latency: got %0d cycles want 4", cyc);
      end
      check_end();
   endtask

   task automatic test_load_seed();
      int cyc;
      issue(2'b01, 7'h20, 8'd0);
      m_lfsr = 7'h20;
      n_checks++;
      if (out_data !== 8'h20 || err_zero_seed !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL load_seed: data=%h err=%b done=%b want 20 0 0", out_data, err_zero_seed, done);
      end
      issue(2'b10, 7'h00, 8'd3);
      push_burst(3);
      drain(3, 20, cyc);
      check_end();
   endtask

   task automatic test_zero_seed();
      int cyc;
      issue(2'b01, 7'h00, 8'd0);
      m_lfsr = 7'h01;
      n_checks++;
      if (err_zero_seed !== 1'b1 || done !== 1'b0 || out_data !== 8'h01) begin
         n_fail++; $display("FAIL zero_seed: err=%b done=%b data=%h want 1 0 01", err_zero_seed, done, out_data);
      end
      tick();
      n_checks++;
      if (err_zero_seed !== 1'b0) begin
         n_fail++; $display("FAIL zero_seed_pulse: got %b want 0", err_zero_seed);
      end
      issue(2'b10, 7'h00, 8'd1);
      push_burst(1);
      drain(1, 10, cyc);
      check_end();
   endtask

   task automatic test_backpressure();
      int cyc;
      out_ready = 1'b0;
      issue(2'b10, 7'h00, 8'd2);
      push_burst(2);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== model_word(m_lfsr) || remaining !== 8'd2) begin
            n_fail++;
            $display("FAIL backpressure_hold: valid=%b data=%h rem=%0d want 1 %h 2",
                     out_valid, out_data, remaining, model_word(m_lfsr));
         end
         tick();
      end
      out_ready = 1'b1;
      drain(2, 10, cyc);
      check_end();
   endtask

   task automatic test_abort();
      exp_t e;
      int   cyc;
      issue(2'b10, 7'h00, 8'd10);
      push_burst(10);
      for (int k = 1; k <= 3; k++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== e.data) begin
            n_fail++; $display("FAIL abort_word%0d: valid=%b data=%h want 1 %h", k, out_valid, out_data, e.data);
         end
         m_lfsr = model_step(m_lfsr);
         if (k == 3) abort = 1'b1;
         tick();
      end
      abort = 1'b0;
      exp_q.delete();
      n_checks++;
      if (remaining !== 8'd0) begin
         n_fail++; $display("FAIL abort_remaining: got %0d want 0", remaining);
      end
      check_end();
      issue(2'b10, 7'h00, 8'd1);
      push_burst(1);
      drain(1, 10, cyc);
      check_end();
   endtask

   task automatic test_zero_len_and_reset();
      int cyc;
      issue(2'b10, 7'h00, 8'd0);
      check_end();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL zero_len_valid: got %b want 0", out_valid);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_abort: done=%b busy=%b want 0 0", done, busy);
      end
      issue(2'b10, 7'h00, 8'd5);
      push_burst(5);
      drain(2, 10, cyc);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h01 || remaining !== 8'd0 || busy !== 1'b0 ||
          cmd_ready !== 1'b1 || out_last !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b data=%h rem=%0d busy=%b ready=%b last=%b done=%b",
                  out_valid, out_data, remaining, busy, cmd_ready, out_last, done);
      end
      exp_q.delete();
      m_lfsr = 7'h01;
      #2 rst = 1'b0;
      tick();
      issue(2'b10, 7'h00, 8'd2);
      push_burst(2);
      drain(2, 10, cyc);
      check_end();
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_seed = 7'h00;
      cmd_len = 8'd0; abort = 1'b0; out_ready = 1'b1;
      m_lfsr = 7'h01;
      tick(); tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_basic_run();
      test_load_seed();
      test_zero_seed();
      test_backpressure();
      test_abort();
      test_zero_len_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
